// File: rtl/guess_block_formatter_pkg.sv
// rtl/guess_block_formatter_pkg.sv - MD5 block constants, block type and padding helper
package guess_block_formatter_pkg;

   localparam int MD5_BLOCK_BITS   = 512;
   localparam int GUESS_BYTES      = 16;
   localparam int LEN_BITS         = 5;
   localparam int MD5_LEN_BYTE_OFS = 56;
   localparam logic [7:0] MD5_PAD_BYTE = 8'h80;

   typedef logic [MD5_BLOCK_BITS-1:0] md5_block_t;

   // Build one padded block from an already-masked guess (char0 in the top byte)
   function automatic md5_block_t md5_pad_block(input logic [8*GUESS_BYTES-1:0] masked,
                                                input logic [LEN_BITS-1:0]      len);
      md5_block_t blk;
      blk = '0;
      for (int k = 0; k < GUESS_BYTES; k++) begin
         blk[8*k +: 8] = masked[8*(GUESS_BYTES-1-k) +: 8];
      end
      blk[8*int'(len) +: 8] = MD5_PAD_BYTE;
      // Bit length is at most 128, so only the lowest length byte is ever nonzero
      blk[8*MD5_LEN_BYTE_OFS +: 8] = {len, 3'b000};
      return blk;
   endfunction

endpackage

// File: rtl/guess_length_scan.sv
// rtl/guess_length_scan.sv - finds the first null byte of a guess and the valid-byte mask
module guess_length_scan
   import guess_block_formatter_pkg::*;
(
   input  logic [8*GUESS_BYTES-1:0] guess,
   output logic [LEN_BITS-1:0]      len,
   output logic [GUESS_BYTES-1:0]   mask
);

   // Priority scan from char0 upward; mask bit k is set for every byte before the null
   always_comb begin
      logic found;
      len   = LEN_BITS'(GUESS_BYTES);
      found = 1'b0;
      for (int k = 0; k < GUESS_BYTES; k++) begin
         if (!found && guess[8*(GUESS_BYTES-1-k) +: 8] == 8'h00) begin
            len   = LEN_BITS'(k);
            found = 1'b1;
         end
      end
      for (int k = 0; k < GUESS_BYTES; k++) begin
         mask[k] = (LEN_BITS'(k) < len);
      end
   end

endmodule

// File: rtl/guess_block_formatter.sv
// rtl/guess_block_formatter.sv - two-stage guess to MD5 padded block formatter
module guess_block_formatter
   import guess_block_formatter_pkg::*;
#(
   parameter int COUNT_WIDTH = 48,
   parameter int MAX_CHARS   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [8*MAX_CHARS-1:0]   guess,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [MD5_BLOCK_BITS-1:0] block,
   output logic [LEN_BITS-1:0]      msg_len,
   output logic [COUNT_WIDTH-1:0]   guess_count
);

   logic [LEN_BITS-1:0]      scan_len;
   logic [GUESS_BYTES-1:0]   scan_mask;
   logic [8*MAX_CHARS-1:0]   masked_guess;

   logic                     s1_valid_q, s1_valid_d;
   logic [8*MAX_CHARS-1:0]   s1_guess_q, s1_guess_d;
   logic [LEN_BITS-1:0]      s1_len_q,   s1_len_d;
   logic                     s2_valid_q, s2_valid_d;
   md5_block_t               block_q,    block_d;
   logic [LEN_BITS-1:0]      msg_len_q,  msg_len_d;
   logic [COUNT_WIDTH-1:0]   count_q,    count_d;

   logic s2_adv;
   logic in_xfer;
   logic out_xfer;

   guess_length_scan u_scan (
      .guess (guess),
      .len   (scan_len),
      .mask  (scan_mask)
   );

   // Zero every byte at and after the terminator so garbage never reaches the block
   always_comb begin
      masked_guess = '0;
      for (int k = 0; k < GUESS_BYTES; k++) begin
         masked_guess[8*(GUESS_BYTES-1-k) +: 8] =
            scan_mask[k] ? guess[8*(GUESS_BYTES-1-k) +: 8] : 8'h00;
      end
   end

   // Handshake and next-state for both pipeline stages and the accept counter
   always_comb begin
      s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
      in_ready = !s1_valid_q || s2_adv;
      in_xfer  = in_valid && in_ready;
      out_xfer = s2_valid_q && out_ready;

      s1_valid_d = s1_valid_q;
      s1_guess_d = s1_guess_q;
      s1_len_d   = s1_len_q;
      if (in_xfer) begin
         s1_valid_d = 1'b1;
         s1_guess_d = masked_guess;
         s1_len_d   = scan_len;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end

      s2_valid_d = s2_valid_q;
      block_d    = block_q;
      msg_len_d  = msg_len_q;
      if (s2_adv) begin
         s2_valid_d = 1'b1;
         block_d    = md5_pad_block(s1_guess_q, s1_len_q);
         msg_len_d  = s1_len_q;
      end else if (out_xfer) begin
         s2_valid_d = 1'b0;
      end

      count_d = in_xfer ? count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : count_q;
   end

   // State registers; reset drops anything in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_guess_q <= '0;
         s1_len_q   <= '0;
         s2_valid_q <= 1'b0;
         block_q    <= '0;
         msg_len_q  <= '0;
         count_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_guess_q <= s1_guess_d;
         s1_len_q   <= s1_len_d;
         s2_valid_q <= s2_valid_d;
         block_q    <= block_d;
         msg_len_q  <= msg_len_d;
         count_q    <= count_d;
      end
   end

   assign out_valid   = s2_valid_q;
   assign block       = block_q;
   assign msg_len     = msg_len_q;
   assign guess_count = count_q;

endmodule

// File: tb/tb_guess_block_formatter.sv
// tb/tb_guess_block_formatter.sv - directed self-checking bench for guess_block_formatter
module tb_guess_block_formatter;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] guess;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] block;
   logic [4:0]   msg_len;
   logic [47:0]  guess_count;

   int errors = 0;
   int checks = 0;

   guess_block_formatter #(.COUNT_WIDTH(48), .MAX_CHARS(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .guess       (guess),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .block       (block),
      .msg_len     (msg_len),
      .guess_count (guess_count)
   );

   always #5 clk = ~clk;

   function automatic logic [511:0] mk(input logic [31:0] w0, input logic [31:0] w1,
                                       input logic [31:0] w2, input logic [31:0] w3,
                                       input logic [31:0] w4, input logic [31:0] w14);
      logic [511:0] b;
      b = '0;
      b[31:0]    = w0;
      b[63:32]   = w1;
      b[95:64]   = w2;
      b[127:96]  = w3;
      b[159:128] = w4;
      b[479:448] = w14;
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_blk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_single(input string tag, input logic [127:0] g,
                             input logic [511:0] exp_blk, input logic [4:0] exp_len,
                             input logic [47:0] exp_cnt);
      in_valid = 1'b1;
      guess    = g;
      tick();
      in_valid = 1'b0;
      guess    = '0;
      tick();
      @(negedge clk);
      chk_val({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk_blk({tag, "_block"}, block, exp_blk);
      chk_val({tag, "_len"}, {59'd0, msg_len}, {59'd0, exp_len});
      chk_val({tag, "_count"}, {16'd0, guess_count}, {16'd0, exp_cnt});
      tick();
   endtask

   logic [127:0] sg [5];
   logic [511:0] sb [5];
   logic [4:0]   sl [5];
   int idx_in;
   int n_out;
   logic ix;
   logic ox;

   initial begin
      sg[0] = {8'h61, 120'h0};
      sg[1] = {16'h6263, 112'h0};
      sg[2] = {24'h646566, 104'h0};
      sg[3] = 128'h0;
      sg[4] = {32'h6768696a, 96'h0};
      sb[0] = mk(32'h00008061, 0, 0, 0, 0, 32'h08);
      sb[1] = mk(32'h00806362, 0, 0, 0, 0, 32'h10);
      sb[2] = mk(32'h80666564, 0, 0, 0, 0, 32'h18);
      sb[3] = mk(32'h00000080, 0, 0, 0, 0, 32'h00);
      sb[4] = mk(32'h6a696867, 32'h80, 0, 0, 0, 32'h20);
      sl[0] = 5'd1; sl[1] = 5'd2; sl[2] = 5'd3; sl[3] = 5'd0; sl[4] = 5'd4;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      guess     = '0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      @(negedge clk);
      chk_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk_val("rst_count", {16'd0, guess_count}, 64'd0);
      chk_blk("rst_block", block, 512'd0);
      chk_val("rst_len", {59'd0, msg_len}, 64'd0);
      chk_val("rst_in_ready", {63'd0, in_ready}, 64'd1);

      run_single("abc", {24'h616263, 104'h0},
                 mk(32'h80636261, 0, 0, 0, 0, 32'h18), 5'd3, 48'd1);
      run_single("empty", 128'h0,
                 mk(32'h00000080, 0, 0, 0, 0, 32'h00), 5'd0, 48'd2);
      run_single("sixteen_a", {16{8'h61}},
                 mk(32'h61616161, 32'h61616161, 32'h61616161, 32'h61616161, 32'h80, 32'h80),
                 5'd16, 48'd3);
      run_single("garbage", {16'h6162, 8'h00, {13{8'hFF}}},
                 mk(32'h00806261, 0, 0, 0, 0, 32'h10), 5'd2, 48'd4);

      // Back-to-back stream with the sink stalled for the first four cycles
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      guess     = sg[0];
      @(negedge clk);
      chk_val("stall_rdy0", {63'd0, in_ready}, 64'd1);
      tick();
      guess = sg[1];
      @(negedge clk);
      chk_val("stall_rdy1", {63'd0, in_ready}, 64'd1);
      tick();
      guess = sg[2];
      @(negedge clk);
      chk_val("stall_rdy2", {63'd0, in_ready}, 64'd0);
      chk_val("stall_valid", {63'd0, out_valid}, 64'd1);
      chk_blk("stall_blk_a", block, sb[0]);
      tick();
      @(negedge clk);
      chk_val("stall_rdy3", {63'd0, in_ready}, 64'd0);
      chk_blk("stall_blk_b", block, sb[0]);
      chk_val("stall_len", {59'd0, msg_len}, {59'd0, sl[0]});
      tick();

      out_ready = 1'b1;
      idx_in    = 2;
      n_out     = 0;
      for (int cyc = 0; cyc < 40 && n_out < 5; cyc++) begin
         in_valid = (idx_in < 5);
         guess    = (idx_in < 5) ? sg[idx_in] : 128'h0;
         @(negedge clk);
         ix = in_valid && in_ready;
         ox = out_valid && out_ready;
         if (ox) begin
            chk_blk($sformatf("stream_blk%0d", n_out), block, sb[n_out]);
            chk_val($sformatf("stream_len%0d", n_out), {59'd0, msg_len}, {59'd0, sl[n_out]});
            n_out++;
         end
         tick();
         if (ix) idx_in++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk_val("stream_outputs", 64'(n_out), 64'd5);
      chk_val("stream_count", {16'd0, guess_count}, 64'd5);
      chk_val("stream_drained", {63'd0, out_valid}, 64'd0);
      tick();

      // Reset with two guesses in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      guess     = sg[0];
      tick();
      guess = sg[1];
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk_val("flight_valid", {63'd0, out_valid}, 64'd1);
      chk_val("flight_count", {16'd0, guess_count}, 64'd7);
      reset = 1'b1;
      tick();
      @(negedge clk);
      chk_val("midrst_valid", {63'd0, out_valid}, 64'd0);
      chk_val("midrst_count", {16'd0, guess_count}, 64'd0);
      chk_blk("midrst_block", block, 512'd0);
      reset     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
         chk_val($sformatf("post_rst_valid%0d", i), {63'd0, out_valid}, 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
